// File: rtl/a2d_spi_resp.sv
// rtl/a2d_spi_resp.sv - SPI responder modelling the 8-channel 12-bit A2D converter
module a2d_spi_resp #(
    parameter logic [2:0] DEF_CH        = 3'd0,
    parameter int         SCLK_MIN_HALF = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic [95:0] ch_data,
    output logic        MISO,
    output logic        cmd_done,
    output logic        frame_err,
    output logic [2:0]  cur_ch,
    output logic [15:0] conv_cnt
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state, state_nxt;
    logic [4:0]  bit_cnt, bit_cnt_nxt;
    logic [15:0] rx_shft, rx_nxt;
    logic [15:0] tx_shft, tx_nxt;
    logic [2:0]  cur_ch_nxt;
    logic [15:0] conv_nxt;
    logic        miso_nxt, done_nxt, err_nxt;

    logic ss_s1, ss_s2, ss_s3;
    logic sclk_s1, sclk_s2, sclk_s3;
    logic mosi_s1, mosi_s2;
    logic ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic [11:0] ch_sel;

    // MISO reaches the pins 3 clk after an SCLK fall, so slower SCLK is mandatory.
    if (SCLK_MIN_HALF < 3) begin : g_sclk_half_too_short
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_s1   <= 1'b1;
            ss_s2   <= 1'b1;
            ss_s3   <= 1'b1;
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            ss_s1   <= SS_n;
            ss_s2   <= ss_s1;
            ss_s3   <= ss_s2;
            sclk_s1 <= SCLK;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            mosi_s1 <= MOSI;
            mosi_s2 <= mosi_s1;
        end
    end

    assign ss_fall   = ss_s3 & ~ss_s2;
    assign ss_rise   = ~ss_s3 & ss_s2;
    assign sclk_rise = ~sclk_s3 & sclk_s2;
    assign sclk_fall = sclk_s3 & ~sclk_s2;

    always_comb begin
        ch_sel = 12'h000;
        for (int i = 0; i < 8; i++) begin
            if (cur_ch == i[2:0]) ch_sel = ch_data[i*12 +: 12];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= 5'd0;
            rx_shft   <= 16'h0000;
            tx_shft   <= 16'h0000;
            cur_ch    <= DEF_CH;
            conv_cnt  <= 16'h0000;
            MISO      <= 1'b0;
            cmd_done  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            rx_shft   <= rx_nxt;
            tx_shft   <= tx_nxt;
            cur_ch    <= cur_ch_nxt;
            conv_cnt  <= conv_nxt;
            MISO      <= miso_nxt;
            cmd_done  <= done_nxt;
            frame_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        rx_nxt      = rx_shft;
        tx_nxt      = tx_shft;
        cur_ch_nxt  = cur_ch;
        conv_nxt    = conv_cnt;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_nxt   = SHIFT;
                    tx_nxt      = {4'h0, ch_sel};
                    bit_cnt_nxt = 5'd0;
                end
            end
            SHIFT: begin
                // Frame end wins over any SCLK edge seen in the same cycle.
                if (ss_rise) begin
                    state_nxt = IDLE;
                    if (bit_cnt == 5'd16) begin
                        cur_ch_nxt = rx_shft[13:11];
                        conv_nxt   = conv_cnt + 16'd1;
                        done_nxt   = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (sclk_rise) begin
                    rx_nxt = {rx_shft[14:0], mosi_s2};
                    if (bit_cnt != 5'd17) bit_cnt_nxt = bit_cnt + 5'd1;
                end else if (sclk_fall && bit_cnt >= 5'd1 && bit_cnt <= 5'd15) begin
                    tx_nxt = {tx_shft[14:0], 1'b0};
                end
            end
            default: state_nxt = IDLE;
        endcase
        miso_nxt = (state_nxt == SHIFT) ? tx_nxt[15] : 1'b0;
    end

endmodule

// File: tb/tb_a2d_spi_resp.sv
// tb/tb_a2d_spi_resp.sv - randomized self-checking bench for a2d_spi_resp
module tb_a2d_spi_resp;

    localparam logic [2:0] DEF_CH = 3'd0;
    localparam int         HALF   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic [95:0] ch_data = '0;
    logic        MISO;
    logic        cmd_done;
    logic        frame_err;
    logic [2:0]  cur_ch;
    logic [15:0] conv_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0]  m_ch;
    logic [15:0] m_cnt;
    logic [15:0] last_resp;
    logic [15:0] resp_hi [4];
    logic [15:0] seq_cmd [4];

    a2d_spi_resp #(.DEF_CH(DEF_CH), .SCLK_MIN_HALF(HALF)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .ch_data(ch_data), .MISO(MISO), .cmd_done(cmd_done), .frame_err(frame_err),
        .cur_ch(cur_ch), .conv_cnt(conv_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] chan(input logic [95:0] d, input logic [2:0] c);
        logic [95:0] t;
        t = d >> (32'(c) * 12);
        return t[11:0];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        SS_n  = 1'b1;
        SCLK  = 1'b0;
        MOSI  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_ch  = DEF_CH;
        m_cnt = 16'h0000;
        repeat (2) @(negedge clk);
    endtask

    // One SPI frame as seen from the initiator: MISO sampled just before each SCLK rise.
    task automatic run_frame(input logic [15:0] cmd, input int nbits, input bit idle_hi,
                             input bit mid_chg, input logic [95:0] mid_val);
        logic [15:0] exp_resp;
        logic [15:0] got;
        int nd, ne, nchk;
        bit good;
        @(negedge clk);
        SCLK = idle_hi;
        MOSI = 1'b0;
        repeat (3) @(negedge clk);
        exp_resp = {4'h0, chan(ch_data, m_ch)};
        SS_n = 1'b0;
        got  = 16'h0000;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? cmd[15-i] : 1'b0;
            if (mid_chg && i == 8) ch_data = mid_val;
            repeat (HALF) @(negedge clk);
            if (i < 16) got = {got[14:0], MISO};
            SCLK = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        if (!idle_hi) begin
            SCLK = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        SS_n = 1'b1;
        nd = 0;
        ne = 0;
        repeat (8) begin
            @(negedge clk);
            nd += int'(cmd_done);
            ne += int'(frame_err);
        end
        good = (nbits == 16);
        nchk = (nbits < 16) ? nbits : 16;
        if (nchk > 0) check("miso_stream", 32'(got), 32'(exp_resp >> (16 - nchk)));
        check("cmd_done_pulses", nd, good ? 1 : 0);
        check("frame_err_pulses", ne, good ? 0 : 1);
        if (good) begin
            m_ch  = cmd[13:11];
            m_cnt = m_cnt + 16'd1;
        end
        check("cur_ch", 32'(cur_ch), 32'(m_ch));
        check("conv_cnt", 32'(conv_cnt), 32'(m_cnt));
        check("miso_idle", 32'(MISO), 32'h0);
        last_resp = got;
    endtask

    task automatic reset_mid_frame(input bit idle_hi);
        logic [15:0] exp_resp;
        int np;
        @(negedge clk);
        SCLK = idle_hi;
        repeat (3) @(negedge clk);
        exp_resp = {4'h0, chan(ch_data, m_ch)};
        SS_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            SCLK = 1'b0;
            MOSI = 1'b1;
            repeat (HALF) @(negedge clk);
            SCLK = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        check("miso_before_rst", 32'(MISO), 32'(exp_resp[9]));
        rst_n = 1'b0;
        np = 0;
        repeat (2) begin
            @(negedge clk);
            np += int'(cmd_done) + int'(frame_err);
        end
        check("rst_miso", 32'(MISO), 32'h0);
        check("rst_cur_ch", 32'(cur_ch), 32'(DEF_CH));
        check("rst_conv_cnt", 32'(conv_cnt), 32'h0);
        rst_n = 1'b1;
        SS_n  = 1'b1;
        SCLK  = 1'b0;
        repeat (8) begin
            @(negedge clk);
            np += int'(cmd_done) + int'(frame_err);
        end
        check("rst_no_pulse", np, 0);
        m_ch  = DEF_CH;
        m_cnt = 16'h0000;
    endtask

    initial begin
        seq_cmd[0] = 16'h0000;
        seq_cmd[1] = 16'h2000;
        seq_cmd[2] = 16'h2800;
        seq_cmd[3] = 16'h1800;

        do_reset();
        check("reset_miso", 32'(MISO), 32'h0);
        check("reset_cmd_done", 32'(cmd_done), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_cur_ch", 32'(cur_ch), 32'(DEF_CH));
        check("reset_conv_cnt", 32'(conv_cnt), 32'h0);

        ch_data = '0;
        ch_data[11:0]  = 12'hABC;
        ch_data[59:48] = 12'h123;
        run_frame(16'h0000, 16, 1'b0, 1'b0, '0);
        check("first_frame_resp", 32'(last_resp), 32'h0ABC);

        run_frame(16'h2000, 16, 1'b1, 1'b0, '0);
        run_frame(16'h2800, 16, 1'b0, 1'b0, '0);
        check("ch4_resp", 32'(last_resp), 32'h0123);
        check("cur_ch_5", 32'(cur_ch), 32'h5);

        run_frame(16'h0000, 9, 1'b1, 1'b0, '0);
        run_frame(16'h2000, 16, 1'b1, 1'b0, '0);
        check("after_err_resp", 32'(last_resp), 32'(chan(ch_data, 3'd5)));

        begin
            logic [95:0] nv;
            nv = ch_data;
            nv[59:48] = 12'hFFF;
            run_frame(16'h2000, 16, 1'b0, 1'b1, nv);
            check("snapshot_resp", 32'(last_resp), 32'h0123);
            run_frame(16'h2000, 16, 1'b0, 1'b0, '0);
            check("updated_resp", 32'(last_resp), 32'h0FFF);
        end

        ch_data = {8{12'hFFF}};
        reset_mid_frame(1'b1);
        reset_mid_frame(1'b0);

        ch_data = {12'h888, 12'h777, 12'h666, 12'h555, 12'h444, 12'h333, 12'h222, 12'h111};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_frame(seq_cmd[i], 16, 1'b1, 1'b0, '0);
            resp_hi[i] = last_resp;
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_frame(seq_cmd[i], 16, 1'b0, 1'b0, '0);
            check("polarity_match", 32'(last_resp), 32'(resp_hi[i]));
        end

        for (int k = 0; k < 60; k++) begin
            int r, nb;
            logic [15:0] cmd;
            logic [95:0] nv;
            bit mc;
            ch_data = {$urandom, $urandom, $urandom};
            nv  = {$urandom, $urandom, $urandom};
            cmd = 16'($urandom);
            r   = $urandom_range(0, 9);
            if (r == 0)      nb = $urandom_range(1, 15);
            else if (r == 1) nb = $urandom_range(17, 18);
            else             nb = 16;
            mc = ($urandom_range(0, 3) == 0);
            run_frame(cmd, nb, 1'($urandom_range(0, 1)), mc, nv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
